date_setter: RTL and testbench

- User-facing date editor that drives the adjust-side interface of the date counter.
- On a mode button it captures the running date and lets the user step day, month and year with up/down buttons.
- Holds the counter in adjust mode while editing and keeps every date it presents valid, including leap years.
- Sits between the debounced button block and the date counter; its outputs also feed the display mux for field blinking.

---
 rtl/date_setter.sv | 183 ++++++++++++++++++
 tb/tb_date_setter.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/date_setter.sv
// rtl/date_setter.sv - date editor driving the date counter's adjust interface.
// Optional DATE_SET_TIMEOUT_EN adds an inactivity auto-commit after TIMEOUT_S seconds.
module date_setter #(
  parameter int YEAR_MAX  = 9999,
  parameter int TIMEOUT_S = 30
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tick_1hz,
  input  logic        btn_mode,
  input  logic        btn_up,
  input  logic        btn_down,
  input  logic [5:0]  cur_day,
  input  logic [3:0]  cur_month,
  input  logic [13:0] cur_year,
  output logic        adjust_mode,
  output logic [5:0]  adj_day,
  output logic [3:0]  adj_month,
  output logic [13:0] adj_year,
  output logic [1:0]  field_sel,
  output logic        blink
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_DAY    = 3'd1;
  localparam logic [2:0] S_MONTH  = 3'd2;
  localparam logic [2:0] S_YEAR   = 3'd3;
  localparam logic [2:0] S_COMMIT = 3'd4;

  localparam logic [13:0] YMAX = 14'(YEAR_MAX);

  logic [2:0]  state_q, state_d;
  logic [5:0]  adj_day_q, adj_day_d;
  logic [3:0]  adj_month_q, adj_month_d;
  logic [13:0] adj_year_q, adj_year_d;
  logic [1:0]  field_sel_q, field_sel_d;
  logic        adjust_mode_q, adjust_mode_d;
  logic        blink_q, blink_d;

`ifdef DATE_SET_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_S + 1);
  logic [TW-1:0] to_cnt_q, to_cnt_d;
`endif

  function automatic logic is_leap(input logic [13:0] y);
    return (((y % 14'd4) == 14'd0) && ((y % 14'd100) != 14'd0)) || ((y % 14'd400) == 14'd0);
  endfunction

  function automatic logic [5:0] max_day(input logic [3:0] m, input logic [13:0] y);
    case (m)
      4'd2:                     return is_leap(y) ? 6'd29 : 6'd28;
      4'd4, 4'd6, 4'd9, 4'd11:  return 6'd30;
      default:                  return 6'd31;
    endcase
  endfunction

  logic        step_en, step_up;
  logic [5:0]  md_cur, md_mon, md_year;
  logic [5:0]  day_next;
  logic [3:0]  mon_next;
  logic [13:0] year_next;

  // Candidate next values for each field; out-of-range captures wrap out on the first step.
  always_comb begin
    step_en = btn_up ^ btn_down;
    step_up = btn_up;
    md_cur  = max_day(adj_month_q, adj_year_q);
    if (step_up) begin
      day_next  = (adj_day_q >= md_cur) ? 6'd1 : adj_day_q + 6'd1;
      mon_next  = (adj_month_q >= 4'd12) ? 4'd1 : adj_month_q + 4'd1;
      year_next = (adj_year_q >= YMAX) ? 14'd0 : adj_year_q + 14'd1;
    end else begin
      day_next  = (adj_day_q <= 6'd1 || adj_day_q > md_cur) ? md_cur : adj_day_q - 6'd1;
      mon_next  = (adj_month_q <= 4'd1 || adj_month_q > 4'd12) ? 4'd12 : adj_month_q - 4'd1;
      year_next = (adj_year_q == 14'd0 || adj_year_q > YMAX) ? YMAX : adj_year_q - 14'd1;
    end
    md_mon  = max_day(mon_next, adj_year_q);
    md_year = max_day(adj_month_q, year_next);
  end

  always_comb begin
    state_d     = state_q;
    adj_day_d   = adj_day_q;
    adj_month_d = adj_month_q;
    adj_year_d  = adj_year_q;
    blink_d     = blink_q;
`ifdef DATE_SET_TIMEOUT_EN
    to_cnt_d    = '0;
`endif
    case (state_q)
      S_IDLE: begin
        if (btn_mode) begin
          adj_day_d   = cur_day;
          adj_month_d = cur_month;
          adj_year_d  = cur_year;
          state_d     = S_DAY;
          blink_d     = 1'b0;
        end
      end
      S_DAY, S_MONTH, S_YEAR: begin
        if (tick_1hz) blink_d = ~blink_q;
        if (btn_mode) begin
          state_d = state_q + 3'd1;
        end else if (step_en) begin
          case (state_q)
            S_DAY: adj_day_d = day_next;
            S_MONTH: begin
              adj_month_d = mon_next;
              if (adj_day_q > md_mon) adj_day_d = md_mon;
            end
            default: begin
              adj_year_d = year_next;
              if (adj_day_q > md_year) adj_day_d = md_year;
            end
          endcase
        end
`ifdef DATE_SET_TIMEOUT_EN
        // Any button restarts the inactivity count and wins over a same-cycle expiry.
        if (btn_mode || btn_up || btn_down) begin
          to_cnt_d = '0;
        end else if (tick_1hz) begin
          if (to_cnt_q == TW'(TIMEOUT_S - 1)) begin
            state_d  = S_COMMIT;
            to_cnt_d = '0;
          end else begin
            to_cnt_d = to_cnt_q + TW'(1);
          end
        end else begin
          to_cnt_d = to_cnt_q;
        end
`endif
      end
      S_COMMIT: begin
        state_d = S_IDLE;
        blink_d = 1'b0;
      end
      default: state_d = S_IDLE;
    endcase

    adjust_mode_d = (state_d != S_IDLE);
    case (state_d)
      S_DAY:   field_sel_d = 2'd1;
      S_MONTH: field_sel_d = 2'd2;
      S_YEAR:  field_sel_d = 2'd3;
      default: field_sel_d = 2'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      adj_day_q     <= 6'd1;
      adj_month_q   <= 4'd1;
      adj_year_q    <= 14'd2024;
      field_sel_q   <= 2'd0;
      adjust_mode_q <= 1'b0;
      blink_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      adj_day_q     <= adj_day_d;
      adj_month_q   <= adj_month_d;
      adj_year_q    <= adj_year_d;
      field_sel_q   <= field_sel_d;
      adjust_mode_q <= adjust_mode_d;
      blink_q       <= blink_d;
    end
  end

`ifdef DATE_SET_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (rst) to_cnt_q <= '0;
    else     to_cnt_q <= to_cnt_d;
  end
`endif

  assign adjust_mode = adjust_mode_q;
  assign adj_day     = adj_day_q;
  assign adj_month   = adj_month_q;
  assign adj_year    = adj_year_q;
  assign field_sel   = field_sel_q;
  assign blink       = blink_q;

endmodule

// File: tb/tb_date_setter.sv
// tb/tb_date_setter.sv - randomized and directed checks of date_setter against a date-level model.
module tb_date_setter;
  localparam int YEAR_MAX = 9999;
  localparam int TO_S     = 3;

  logic        clk = 1'b0;
  logic        rst, tick_1hz, btn_mode, btn_up, btn_down;
  logic [5:0]  cur_day;
  logic [3:0]  cur_month;
  logic [13:0] cur_year;
  logic        adjust_mode, blink;
  logic [5:0]  adj_day;
  logic [3:0]  adj_month;
  logic [13:0] adj_year;
  logic [1:0]  field_sel;

  int n_cmp = 0;
  int n_fail = 0;

  date_setter #(.YEAR_MAX(YEAR_MAX), .TIMEOUT_S(TO_S)) dut (
    .clk(clk), .rst(rst), .tick_1hz(tick_1hz), .btn_mode(btn_mode),
    .btn_up(btn_up), .btn_down(btn_down), .cur_day(cur_day),
    .cur_month(cur_month), .cur_year(cur_year), .adjust_mode(adjust_mode),
    .adj_day(adj_day), .adj_month(adj_month), .adj_year(adj_year),
    .field_sel(field_sel), .blink(blink)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit leap(input int y);
    return (y % 4 == 0 && y % 100 != 0) || (y % 400 == 0);
  endfunction

  function automatic int mdays(input int m, input int y);
    if (m == 2) return leap(y) ? 29 : 28;
    if (m == 4 || m == 6 || m == 9 || m == 11) return 30;
    return 31;
  endfunction

  // Model: editing phase 0=idle, 1=day, 2=month, 3=year, 4=commit.
  int  m_ph, m_d, m_m, m_y, m_to;
  bit  m_blink, started = 0;

  always @(posedge clk) begin
    int md;
    if (rst) begin
      started = 1;
      m_ph = 0; m_d = 1; m_m = 1; m_y = 2024; m_blink = 0; m_to = 0;
    end else if (m_ph == 0) begin
      if (btn_mode) begin
        m_d = cur_day; m_m = cur_month; m_y = cur_year; m_ph = 1; m_blink = 0;
      end
    end else if (m_ph == 4) begin
      m_ph = 0; m_blink = 0;
    end else begin
      if (tick_1hz) m_blink = !m_blink;
      if (btn_mode) m_ph = m_ph + 1;
      else if (btn_up != btn_down) begin
        if (m_ph == 1) begin
          md = mdays(m_m, m_y);
          if (m_d > md) m_d = btn_up ? 1 : md;
          else if (btn_up) m_d = m_d % md + 1;
          else m_d = (m_d + md - 2) % md + 1;
        end else if (m_ph == 2) begin
          if (m_m < 1 || m_m > 12) m_m = btn_up ? 1 : 12;
          else m_m = btn_up ? (m_m % 12 + 1) : ((m_m + 10) % 12 + 1);
          if (m_d > mdays(m_m, m_y)) m_d = mdays(m_m, m_y);
        end else begin
          m_y = btn_up ? (m_y + 1) % (YEAR_MAX + 1) : (m_y + YEAR_MAX) % (YEAR_MAX + 1);
          if (m_d > mdays(m_m, m_y)) m_d = mdays(m_m, m_y);
        end
      end
`ifdef DATE_SET_TIMEOUT_EN
      if (btn_mode || btn_up || btn_down) m_to = 0;
      else if (tick_1hz) begin
        m_to++;
        if (m_to == TO_S) begin m_ph = 4; m_to = 0; end
      end
`endif
    end
    if (m_ph == 0 || m_ph == 4) m_to = 0;
  end

  always @(negedge clk) begin
    if (started) begin
      chk("adj_day", adj_day, m_d);
      chk("adj_month", adj_month, m_m);
      chk("adj_year", adj_year, m_y);
      chk("adjust_mode", adjust_mode, (m_ph != 0) ? 1 : 0);
      chk("field_sel", field_sel, (m_ph >= 1 && m_ph <= 3) ? m_ph : 0);
      chk("blink", blink, m_blink);
    end
  end

  task automatic step(input bit r, input bit md, input bit up, input bit dn, input bit tk);
    rst = r; btn_mode = md; btn_up = up; btn_down = dn; tick_1hz = tk;
    @(posedge clk); #1;
    rst = 0; btn_mode = 0; btn_up = 0; btn_down = 0; tick_1hz = 0;
  endtask

  task automatic set_cur(input int d, input int m, input int y);
    cur_day = 6'(d); cur_month = 4'(m); cur_year = 14'(y);
  endtask

  task automatic chk_date(input string name, input int d, input int m, input int y);
    chk({name, "_day"}, adj_day, d);
    chk({name, "_month"}, adj_month, m);
    chk({name, "_year"}, adj_year, y);
  endtask

  initial begin
    rst = 0; tick_1hz = 0; btn_mode = 0; btn_up = 0; btn_down = 0;
    set_cur(15, 6, 2000);
    @(posedge clk); #1;

    step(1, 0, 0, 0, 0);
    chk_date("reset", 1, 1, 2024);
    chk("reset_am", adjust_mode, 0);
    chk("reset_fs", field_sel, 0);
    step(0, 0, 1, 0, 0);
    chk_date("idle_up", 1, 1, 2024);

    set_cur(29, 2, 2024);
    step(0, 1, 0, 0, 0);
    chk("enter_fs", field_sel, 1);
    chk("enter_am", adjust_mode, 1);
    step(0, 1, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    chk("to_year_fs", field_sel, 3);
    step(0, 0, 1, 0, 0);
    chk_date("leap_up", 28, 2, 2025);
    step(0, 0, 0, 1, 0);
    chk_date("leap_dn", 28, 2, 2024);
    step(0, 1, 0, 0, 0);
    chk("commit_am", adjust_mode, 1);
    chk("commit_fs", field_sel, 0);
    step(0, 0, 0, 0, 0);
    chk("after_commit_am", adjust_mode, 0);
    chk_date("committed", 28, 2, 2024);

    set_cur(31, 1, 2023);
    step(0, 1, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    chk("month_fs", field_sel, 2);
    step(0, 0, 1, 0, 0);
    chk_date("mon_clamp", 28, 2, 2023);
    for (int i = 0; i < 10; i++) step(0, 0, 1, 0, 0);
    chk_date("mon_12", 28, 12, 2023);
    step(0, 0, 1, 0, 0);
    chk_date("mon_wrap", 28, 1, 2023);
    step(0, 1, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0);

    set_cur(1, 4, 9999);
    step(0, 1, 0, 0, 0);
    step(0, 0, 0, 1, 0);
    chk_date("day_dn_wrap", 30, 4, 9999);
    step(0, 0, 1, 0, 0);
    chk_date("day_up_wrap", 1, 4, 9999);
    step(0, 0, 1, 1, 0);
    chk_date("up_dn_both", 1, 4, 9999);
    step(0, 1, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    step(0, 0, 1, 0, 0);
    chk_date("year_wrap", 1, 4, 0);
    step(0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0);

    set_cur(10, 13, 2100);
    step(0, 1, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    step(0, 0, 0, 1, 0);
    chk_date("mon13_dn", 10, 12, 2100);
    step(1, 0, 0, 0, 0);
    chk_date("rst_mid", 1, 1, 2024);
    chk("rst_mid_am", adjust_mode, 0);
    chk("rst_mid_fs", field_sel, 0);

    step(0, 1, 0, 0, 0);
`ifdef DATE_SET_TIMEOUT_EN
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    step(0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    chk("to_restart_fs", field_sel, 1);
    step(0, 0, 0, 0, 1);
    chk("to_commit_fs", field_sel, 0);
    chk("to_commit_am", adjust_mode, 1);
    step(0, 0, 0, 0, 0);
    chk("to_idle_am", adjust_mode, 0);
`else
    for (int i = 0; i < 40; i++) step(0, 0, 0, 0, 1);
    chk("no_to_fs", field_sel, 1);
    chk("no_to_am", adjust_mode, 1);
    for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0);
`endif

    for (int i = 0; i < 4000; i++) begin
      set_cur($urandom_range(1, 31), $urandom_range(0, 15), $urandom_range(0, 9999));
      step($urandom_range(0, 199) == 0, $urandom_range(0, 6) == 0,
           $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0,
           $urandom_range(0, 3) == 0);
    end

    @(negedge clk); #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
